// File: rtl/cpu_pkg.sv
// Shared fetch-path definitions: instruction granule, default reset vector
// and the prefetch queue entry layout for the default widths.
package cpu_pkg;

   localparam int unsigned INSTR_BYTES    = 4;
   localparam int unsigned WORDSIZE_DEF   = 64;
   localparam int unsigned INSTR_SIZE_DEF = 32;
   localparam logic [63:0] RESET_ADDR_DEF = 64'h0;

   typedef struct packed {
      logic [INSTR_SIZE_DEF-1:0] instr;
      logic [WORDSIZE_DEF-1:0]   pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: small synchronous FIFO holding {instr, pc} entries.
// Flush wins over push/pop. The head is read straight from storage so the
// instruction outputs are register-driven. Never pushed when full: the
// parent only issues requests it has a slot for.
module fetch_queue #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 96
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   input  logic                   flush,
   output logic [$clog2(DEPTH):0] occupancy,
   output logic [WIDTH-1:0]       head
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is 2^n)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   occupancy <= occupancy + 1'b1;
            2'b01:   occupancy <= occupancy - 1'b1;
            default: occupancy <= occupancy;
         endcase
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Handshaked instruction fetcher. Owns the fetch PC, issues in-order word
// requests against a credit limit so every response has a queue slot, and
// squashes in-flight responses on redirect.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN -- a misaligned redirect
// sets a sticky error and halts issue until an aligned redirect. Without it
// the low two address bits of a redirect are ignored.
module instruction_fetch_unit
   import cpu_pkg::*;
#(
   parameter int                  WORDSIZE         = 64,
   parameter int                  INSTRUCTION_SIZE = 32,
   parameter int                  DEPTH            = 2,
   parameter logic [WORDSIZE-1:0] RESET_ADDR       = WORDSIZE'(RESET_ADDR_DEF)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        redirect_valid,
   input  logic [WORDSIZE-1:0]         redirect_addr,
   output logic                        req_valid,
   input  logic                        req_ready,
   output logic [WORDSIZE-1:0]         req_addr,
   input  logic                        resp_valid,
   input  logic [INSTRUCTION_SIZE-1:0] resp_data,
   output logic                        instr_valid,
   input  logic                        instr_ready,
   output logic [INSTRUCTION_SIZE-1:0] instr,
   output logic [WORDSIZE-1:0]         instr_pc,
   output logic                        misalign_err
);

   localparam int CNT_W   = $clog2(DEPTH + 1) + 1;
   localparam int OCC_W   = $clog2(DEPTH) + 1;
   localparam int ENTRY_W = INSTRUCTION_SIZE + WORDSIZE;
   localparam logic [WORDSIZE-1:0] STEP    = WORDSIZE'(INSTR_BYTES);
   localparam logic [CNT_W:0]      DEPTH_C = (CNT_W + 1)'(DEPTH);

   logic [WORDSIZE-1:0] fetch_pc;
   logic [WORDSIZE-1:0] resp_pc;
   logic [WORDSIZE-1:0] redirect_pc;
   logic [CNT_W-1:0]    outstanding;
   logic [CNT_W-1:0]    drop_cnt;
   logic [OCC_W-1:0]    occupancy;
   logic [ENTRY_W-1:0]  head;
   logic [CNT_W:0]      in_use;
   logic                halt;
   logic                credit;
   logic                req_fire;
   logic                drop_resp;
   logic                push;
   logic                pop;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic misalign_q;

   // Sticky misalignment flag: every redirect re-evaluates it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              misalign_q <= 1'b0;
      else if (redirect_valid) misalign_q <= |redirect_addr[1:0];
   end

   assign redirect_pc  = redirect_addr;
   assign halt         = misalign_q;
   assign misalign_err = misalign_q;
`else
   assign redirect_pc  = redirect_addr & ~WORDSIZE'(3);
   assign halt         = 1'b0;
   assign misalign_err = 1'b0;
`endif

   // Queue slots already spoken for: buffered entries plus in-flight requests
   assign in_use    = (CNT_W + 1)'(occupancy) + (CNT_W + 1)'(outstanding);
   assign credit    = in_use < DEPTH_C;
   // rst_n gating keeps the request port quiet while held in reset
   assign req_valid = rst_n && !redirect_valid && !halt && credit;
   assign req_addr  = fetch_pc;
   assign req_fire  = req_valid && req_ready;

   assign drop_resp   = resp_valid && (drop_cnt != '0);
   assign push        = resp_valid && !drop_resp && !redirect_valid;
   assign instr_valid = (occupancy != '0) && !redirect_valid;
   assign pop         = instr_valid && instr_ready;

   // PCs, in-flight count and squash count; redirect overrides the PCs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc    <= RESET_ADDR;
         resp_pc     <= RESET_ADDR;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         if (req_fire) fetch_pc <= fetch_pc + STEP;
         if (push)     resp_pc  <= resp_pc + STEP;

         case ({req_fire, resp_valid})
            2'b10:   outstanding <= outstanding + CNT_W'(1);
            2'b01:   if (outstanding != '0) outstanding <= outstanding - CNT_W'(1);
            default: outstanding <= outstanding;
         endcase

         if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            resp_pc  <= redirect_pc;
            // outstanding already includes responses marked by an earlier
            // redirect, so after this one every in-flight response is stale;
            // a response landing this cycle is itself discarded.
            if (resp_valid && outstanding != '0) drop_cnt <= outstanding - CNT_W'(1);
            else                                 drop_cnt <= outstanding;
         end else if (drop_resp) begin
            drop_cnt <= drop_cnt - CNT_W'(1);
         end
      end
   end

   fetch_queue #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fetch_queue (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data ({resp_data, resp_pc}),
      .pop       (pop),
      .flush     (redirect_valid),
      .occupancy (occupancy),
      .head      (head)
   );

   assign instr    = head[ENTRY_W-1:WORDSIZE];
   assign instr_pc = head[WORDSIZE-1:0];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a small in-order memory
// model of configurable latency. Honors FETCH_MISALIGN_CHECK_EN.
module tb_instruction_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        redirect_valid;
   logic [63:0] redirect_addr;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_addr;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [63:0] instr_pc;
   logic        misalign_err;

   typedef struct {
      logic [63:0] addr;
      int          due;
   } mem_t;

   mem_t        mq[$];
   logic [63:0] reqs[$];
   logic [63:0] pops[$];
   int          cyc;
   int          lat;
   int          bad_data;
   int          errors;
   int          checks;

   instruction_fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_addr       (req_addr),
      .resp_valid     (resp_valid),
      .resp_data      (resp_data),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .misalign_err   (misalign_err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word_at(input logic [63:0] a);
      return {8'hA5, a[23:0]};
   endfunction

   // One clock: sample handshakes before the edge, advance memory model after
   task automatic cycle();
      logic        acc;
      logic [63:0] a;
      mem_t        m;
      #1;
      acc = req_valid && req_ready;
      a   = req_addr;
      if (acc) reqs.push_back(a);
      if (instr_valid && instr_ready) begin
         pops.push_back(instr_pc);
         if (instr !== word_at(instr_pc)) bad_data++;
      end
      @(posedge clk);
      cyc++;
      if (resp_valid && mq.size() > 0) void'(mq.pop_front());
      if (acc) begin
         m.addr = a;
         m.due  = cyc + lat - 1;
         mq.push_back(m);
      end
      @(negedge clk);
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         resp_valid = 1'b1;
         resp_data  = word_at(mq[0].addr);
      end else begin
         resp_valid = 1'b0;
         resp_data  = '0;
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_addr  = '0;
      resp_valid     = 1'b0;
      resp_data      = '0;
      instr_ready    = 1'b1;
      req_ready      = 1'b1;
      lat            = 1;
      mq.delete();
      reqs.delete();
      pops.delete();
      bad_data       = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;
      resp_valid = 1'b0; resp_data = '0; instr_ready = 1'b1; req_ready = 1'b1;
      lat = 1;
      @(negedge clk); #1;
      checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b want 0", req_valid); end
      checks++; if (req_addr !== 64'h0) begin errors++; $display("FAIL reset_req_addr got %h want 0", req_addr); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid got %b want 0", instr_valid); end
      checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", instr); end
      checks++; if (instr_pc !== 64'h0) begin errors++; $display("FAIL reset_instr_pc got %h want 0", instr_pc); end
      checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b want 0", misalign_err); end
      rst_n = 1'b1; #1;
      checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid got %b want 1", req_valid); end
      checks++; if (req_addr !== 64'h0) begin errors++; $display("FAIL first_req_addr got %h want 0", req_addr); end
   endtask

   task automatic test_stream();
      logic ok;
      do_reset();
      cycle();
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stream_no_bypass got %b want 0", instr_valid); end
      cycle();
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 64'h0 || instr !== word_at(64'h0)) begin
         errors++; $display("FAIL stream_first_instr got v=%b pc=%h i=%h want v=1 pc=0 i=%h", instr_valid, instr_pc, instr, word_at(64'h0)); end
      repeat (12) cycle();
      ok = (reqs.size() >= 5);
      for (int i = 0; i < 5 && i < reqs.size(); i++) if (reqs[i] !== 64'(4 * i)) ok = 1'b0;
      checks++; if (!ok) begin errors++; $display("FAIL stream_req_seq got n=%0d first=%h want 0,4,8,c,10", reqs.size(), (reqs.size() > 0) ? reqs[0] : 64'hx); end
      ok = (pops.size() >= 4);
      for (int i = 0; i < 4 && i < pops.size(); i++) if (pops[i] !== 64'(4 * i)) ok = 1'b0;
      checks++; if (!ok) begin errors++; $display("FAIL stream_pc_seq got n=%0d first=%h want 0,4,8,c", pops.size(), (pops.size() > 0) ? pops[0] : 64'hx); end
      checks++; if (bad_data != 0) begin errors++; $display("FAIL stream_data got %0d bad words want 0", bad_data); end
   endtask

   task automatic test_backpressure();
      do_reset();
      instr_ready = 1'b0;
      repeat (10) cycle();
      checks++; if (reqs.size() != 2) begin errors++; $display("FAIL bp_req_count got %0d want 2", reqs.size()); end
      checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid got %b want 0", req_valid); end
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 64'h0) begin errors++; $display("FAIL bp_head got v=%b pc=%h want v=1 pc=0", instr_valid, instr_pc); end
      instr_ready = 1'b1;
      cycle();
      checks++; if (req_valid !== 1'b1 || req_addr !== 64'h8) begin errors++; $display("FAIL bp_resume got v=%b a=%h want v=1 a=8", req_valid, req_addr); end
      checks++; if (instr_pc !== 64'h4) begin errors++; $display("FAIL bp_next_pc got %h want 4", instr_pc); end
   endtask

   task automatic test_redirect_drop();
      logic stale;
      do_reset();
      lat = 3;
      cycle();
      cycle();
      checks++; if (reqs.size() != 2) begin errors++; $display("FAIL drop_outstanding got %0d want 2", reqs.size()); end
      redirect_valid = 1'b1;
      redirect_addr  = 64'h100;
      #1;
      checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL drop_req_during_redirect got %b want 0", req_valid); end
      reqs.delete();
      pops.delete();
      cycle();
      redirect_valid = 1'b0;
      repeat (10) cycle();
      checks++; if (reqs.size() == 0 || reqs[0] !== 64'h100) begin errors++; $display("FAIL drop_first_req got %h want 100", (reqs.size() > 0) ? reqs[0] : 64'hx); end
      checks++; if (pops.size() == 0 || pops[0] !== 64'h100) begin errors++; $display("FAIL drop_first_pc got %h want 100", (pops.size() > 0) ? pops[0] : 64'hx); end
      stale = 1'b0;
      foreach (pops[i]) if (pops[i] < 64'h100) stale = 1'b1;
      checks++; if (stale || bad_data != 0) begin errors++; $display("FAIL drop_stale got stale=%b bad=%0d want 0 0", stale, bad_data); end
   endtask

   task automatic test_redirect_same_cycle();
      do_reset();
      cycle();
      cycle();
      pops.delete();
      redirect_valid = 1'b1;
      redirect_addr  = 64'h40;
      #1;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL same_instr_valid got %b want 0", instr_valid); end
      cycle();
      checks++; if (pops.size() != 0) begin errors++; $display("FAIL same_no_pop got %0d pops want 0", pops.size()); end
      redirect_valid = 1'b0;
      #1;
      checks++; if (req_valid !== 1'b1 || req_addr !== 64'h40) begin errors++; $display("FAIL same_target got v=%b a=%h want v=1 a=40", req_valid, req_addr); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL same_flushed got %b want 0", instr_valid); end
      repeat (4) cycle();
      checks++; if (pops.size() == 0 || pops[0] !== 64'h40) begin errors++; $display("FAIL same_next_pc got %h want 40", (pops.size() > 0) ? pops[0] : 64'hx); end
   endtask

   task automatic test_misalign();
      do_reset();
      redirect_valid = 1'b1;
      redirect_addr  = 64'h102;
      cycle();
      redirect_valid = 1'b0;
      #1;
`ifdef FETCH_MISALIGN_CHECK_EN
      checks++; if (misalign_err !== 1'b1 || req_valid !== 1'b0) begin errors++; $display("FAIL mis_set got err=%b v=%b want 1 0", misalign_err, req_valid); end
      repeat (3) cycle();
      checks++; if (req_valid !== 1'b0 || reqs.size() != 0) begin errors++; $display("FAIL mis_halt got v=%b n=%0d want 0 0", req_valid, reqs.size()); end
`else
      checks++; if (misalign_err !== 1'b0 || req_valid !== 1'b1 || req_addr !== 64'h100) begin
         errors++; $display("FAIL mis_align got err=%b v=%b a=%h want 0 1 100", misalign_err, req_valid, req_addr); end
      repeat (3) cycle();
`endif
      reqs.delete();
      pops.delete();
      redirect_valid = 1'b1;
      redirect_addr  = 64'h200;
      cycle();
      redirect_valid = 1'b0;
      repeat (8) cycle();
      checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL mis_clear got %b want 0", misalign_err); end
      checks++; if (reqs.size() == 0 || reqs[0] !== 64'h200) begin errors++; $display("FAIL mis_resume_req got %h want 200", (reqs.size() > 0) ? reqs[0] : 64'hx); end
      checks++; if (pops.size() == 0 || pops[0] !== 64'h200) begin errors++; $display("FAIL mis_resume_pc got %h want 200", (pops.size() > 0) ? pops[0] : 64'hx); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      instr_ready = 1'b0;
      repeat (6) cycle();
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 64'h0) begin errors++; $display("FAIL mid_full got v=%b pc=%h want 1 0", instr_valid, instr_pc); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL mid_req_valid got %b want 0", req_valid); end
      checks++; if (req_addr !== 64'h0) begin errors++; $display("FAIL mid_req_addr got %h want 0", req_addr); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mid_instr_valid got %b want 0", instr_valid); end
      checks++; if (instr !== 32'h0 || instr_pc !== 64'h0) begin errors++; $display("FAIL mid_head got i=%h pc=%h want 0 0", instr, instr_pc); end
      checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL mid_misalign got %b want 0", misalign_err); end
      @(negedge clk);
      mq.delete();
      resp_valid  = 1'b0;
      instr_ready = 1'b1;
      rst_n       = 1'b1;
      #1;
      checks++; if (req_valid !== 1'b1 || req_addr !== 64'h0) begin errors++; $display("FAIL mid_restart got v=%b a=%h want 1 0", req_valid, req_addr); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      cyc    = 0;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_drop();
      test_redirect_same_cycle();
      test_misalign();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
